cnn_pool2x2_stream: RTL
=======================

// Module: cnn_pool2x2_stream
// PURPOSE
// Parametrised 2x2/stride-2 pooling engine for the CNN layer chain; successor to the fixed 8-channel maxpool stage.
// Sweeps an OUT_H x OUT_W output map and issues one (row,col) read per cycle to the upstream pixel buffer.
// The buffer returns the four quadrant words (even/odd row x even/odd col) one cycle later.
// Pools each channel and emits one save per output pixel with matching address, plus first-save and done pulses.
// PARAMETERS
// DATA_W  16  bits per channel element, signed two's complement
// CH      8   channels packed per word; word width CH*DATA_W, channel k at [k*DATA_W +: DATA_W]
// OUT_W   16  output map width (columns), >=1
// OUT_H   16  output map height (rows), >=1
// ADDR_W  16  width of all row/col address ports
// PORTS
// clk                   in   1          clock; all state updates on rising edge
// rst                   in   1          asynchronous, active-high reset
// start                 in   1          begin a map sweep; sampled only in IDLE
// in_ee/in_eo/in_oe/in_oo in CH*DATA_W quadrant words, valid the cycle after their read
// read_pixel_signal     out  1          read request valid this cycle
// read_row_addr         out  ADDR_W     output-map row being read
// read_col_addr         out  ADDR_W     output-map column being read
// save_enable           out  1          output_data/output_row/output_col valid this cycle
// output_row            out  ADDR_W     row of the pooled pixel
// output_col            out  ADDR_W     column of the pooled pixel
// output_data           out  CH*DATA_W  pooled word
// first_save            out  1          one-cycle pulse with the first save of a sweep
// done                  out  1          one-cycle pulse with the last save of a sweep
// busy                  out  1          high from the cycle after start until the cycle after done
// BEHAVIOUR
// - Reset: FSM=IDLE. All counters, pipeline registers and outputs go to 0.
//   This includes read_pixel_signal, save_enable, addresses, output_data, first_save, done and busy.
// - FSM IDLE -> RUN on start=1. RUN -> DRAIN after the read of (OUT_H-1, OUT_W-1) is issued.
// - DRAIN lasts exactly 2 cycles, then returns to IDLE. start is ignored outside IDLE.
// - RUN: read_pixel_signal=1 every cycle. The column counter steps 0..OUT_W-1 and wraps to 0.
//   The row counter increments on a column wrap. Both counters clear on entering RUN.
// - Read/return timing: read issued in cycle N. Quadrant words are sampled at the end of cycle N+1.
//   Registered output_data, row, col and save_enable are valid in cycle N+2. Latency is fixed at 2 cycles.
// - Throughput: 1 pixel/cycle with no bubbles. A sweep takes OUT_H*OUT_W+2 cycles from the first read.
// - Pooling: per channel, the signed maximum of the 4 quadrant elements. The result is exact; no saturation.
// - first_save is asserted with the save of (0,0). done is asserted with the save of (OUT_H-1, OUT_W-1).
//   When OUT_H=OUT_W=1, both pulse in the same cycle.
// - save_enable=0 outside valid save cycles; output_data holds its last value then.
// - Reset mid-sweep aborts immediately with no partial done. The next start begins again at (0,0).
// - start coincident with done (last DRAIN cycle) is ignored. A new sweep needs start while in IDLE.
// CONFIGURATION
// POOL_AVG_EN defined:
//   - Adds input pool_mode (1 bit, sampled on start, held for the sweep). 0 = max, 1 = average.
//   - Average: sign-extend the 4 elements to DATA_W+2, sum, arithmetic right shift by 2 (floor toward -inf).
//     Take the low DATA_W bits; the result always fits.
// POOL_AVG_EN undefined: port pool_mode is absent and max pooling only is built.
// TESTING
// T1 reset: assert rst mid-sweep -> all outputs 0 in that cycle, FSM IDLE, no done pulse.
// T2 OUT_W=OUT_H=2, start -> reads (0,0),(0,1),(1,0),(1,1) in 4 consecutive cycles.
//    Saves follow 2 cycles later with the same addresses; first_save on (0,0); done on (1,1); 6 cycles total.
// T3 signed max, ch0 quads {-5,3,-1,2} -> 3; ch7 quads {-8,-2,-3,-4} -> -2; other channels 0 -> 0.
// T4 POOL_AVG_EN, pool_mode=1, ch0 quads {7,0,0,0} -> 1; {-1,0,0,0} -> -1; {32767 x4} -> 32767.
// T5 start pulsed during RUN and at the done cycle -> ignored; a start two cycles after done -> new sweep from (0,0).
// T6 OUT_W=3, OUT_H=1 -> column wraps 0,1,2 with row fixed at 0; done on (0,2).

Source files
------------

// File: rtl/cnn_pool2x2_stream.sv
// 2x2/stride-2 pooling engine: sweeps an OUT_H x OUT_W map, one read per cycle, saves 2 cycles later.
// Optional build macro POOL_AVG_EN adds pool_mode_i (0 = max, 1 = floor average); default is max only.
//
// state  | meaning
// IDLE   | waiting for start_i
// RUN    | one quadrant read issued per cycle
// DRAIN0 | pipeline flush, second-to-last save
// DRAIN1 | pipeline flush, last save with done_o
module cnn_pool2x2_stream #(
  parameter int DATA_W = 16,
  parameter int CH     = 8,
  parameter int OUT_W  = 16,
  parameter int OUT_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
`ifdef POOL_AVG_EN
  input  logic                 pool_mode_i,
`endif
  input  logic [CH*DATA_W-1:0] in_ee_i,
  input  logic [CH*DATA_W-1:0] in_eo_i,
  input  logic [CH*DATA_W-1:0] in_oe_i,
  input  logic [CH*DATA_W-1:0] in_oo_i,
  output logic                 read_pixel_signal_o,
  output logic [ADDR_W-1:0]    read_row_addr_o,
  output logic [ADDR_W-1:0]    read_col_addr_o,
  output logic                 save_enable_o,
  output logic [ADDR_W-1:0]    output_row_o,
  output logic [ADDR_W-1:0]    output_col_o,
  output logic [CH*DATA_W-1:0] output_data_o,
  output logic                 first_save_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int WORD_W = CH * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN0, DRAIN1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   row_q, col_q;
  logic                rd_vld_q;
  logic [ADDR_W-1:0]   rd_row_q, rd_col_q;
  logic                save_q, first_q, done_q;
  logic [ADDR_W-1:0]   out_row_q, out_col_q;
  logic [WORD_W-1:0]   data_q;
  logic [WORD_W-1:0]   pool_d;
`ifdef POOL_AVG_EN
  logic                mode_q;
`endif

  function automatic logic [DATA_W-1:0] max4(input logic signed [DATA_W-1:0] a,
                                             input logic signed [DATA_W-1:0] b,
                                             input logic signed [DATA_W-1:0] c,
                                             input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

`ifdef POOL_AVG_EN
  // Two guard bits hold the 4-term sum; the floored quotient always fits back in DATA_W.
  function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c,
                                             input logic [DATA_W-1:0] d);
    logic signed [DATA_W+1:0] s;
    logic signed [DATA_W+1:0] q;
    s = $signed({{2{a[DATA_W-1]}}, a}) + $signed({{2{b[DATA_W-1]}}, b})
      + $signed({{2{c[DATA_W-1]}}, c}) + $signed({{2{d[DATA_W-1]}}, d});
    q = s >>> 2;
    return q[DATA_W-1:0];
  endfunction
`endif

  always_comb begin
    pool_d = '0;
    for (int k = 0; k < CH; k++) begin
`ifdef POOL_AVG_EN
      if (mode_q)
        pool_d[k*DATA_W +: DATA_W] = avg4(in_ee_i[k*DATA_W +: DATA_W], in_eo_i[k*DATA_W +: DATA_W],
                                          in_oe_i[k*DATA_W +: DATA_W], in_oo_i[k*DATA_W +: DATA_W]);
      else
        pool_d[k*DATA_W +: DATA_W] = max4(in_ee_i[k*DATA_W +: DATA_W], in_eo_i[k*DATA_W +: DATA_W],
                                          in_oe_i[k*DATA_W +: DATA_W], in_oo_i[k*DATA_W +: DATA_W]);
`else
      pool_d[k*DATA_W +: DATA_W] = max4(in_ee_i[k*DATA_W +: DATA_W], in_eo_i[k*DATA_W +: DATA_W],
                                        in_oe_i[k*DATA_W +: DATA_W], in_oo_i[k*DATA_W +: DATA_W]);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      save_q    <= 1'b0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      data_q    <= '0;
`ifdef POOL_AVG_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      // Stage 1 tracks the read in flight; stage 2 captures the returned quadrants.
      rd_vld_q <= (state_q == RUN);
      rd_row_q <= row_q;
      rd_col_q <= col_q;
      save_q   <= rd_vld_q;
      first_q  <= rd_vld_q && (rd_row_q == '0) && (rd_col_q == '0);
      done_q   <= rd_vld_q && (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);
      if (rd_vld_q) begin
        data_q    <= pool_d;
        out_row_q <= rd_row_q;
        out_col_q <= rd_col_q;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            row_q   <= '0;
            col_q   <= '0;
`ifdef POOL_AVG_EN
            mode_q  <= pool_mode_i;
`endif
          end
        end
        RUN: begin
          if (col_q == LAST_COL) begin
            col_q <= '0;
            if (row_q == LAST_ROW) begin
              row_q   <= '0;
              state_q <= DRAIN0;
            end else begin
              row_q <= row_q + ADDR_W'(1);
            end
          end else begin
            col_q <= col_q + ADDR_W'(1);
          end
        end
        DRAIN0:  state_q <= DRAIN1;
        DRAIN1:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_pixel_signal_o = (state_q == RUN);
  assign read_row_addr_o     = row_q;
  assign read_col_addr_o     = col_q;
  assign save_enable_o       = save_q;
  assign output_row_o        = out_row_q;
  assign output_col_o        = out_col_q;
  assign output_data_o       = data_q;
  assign first_save_o        = first_q;
  assign done_o              = done_q;
  assign busy_o              = (state_q != IDLE);

endmodule
